// File: rtl/vdp_super_palette.sv
// 256 x 24-bit palette for the super-res video path, self-filling after reset.
// Optional CPU readback port is built when SUPER_PALETTE_READBACK_EN is defined.
module vdp_super_palette #(
  parameter int         INIT_PALETTE     = 0,
  parameter logic [7:0] INIT_START_INDEX = 8'd0
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [7:0] palette_addr,
  output logic [7:0] palette_r,
  output logic [7:0] palette_g,
  output logic [7:0] palette_b,
  input  logic       cpu_index_strobe,
  input  logic       cpu_data_strobe,
  input  logic [7:0] cpu_data,
  input  logic       cpu_rd_strobe,
  output logic [7:0] cpu_rd_data,
  output logic       init_busy
);

  // state   | meaning
  // ST_INIT | sequencer writing default palette, CPU ignored, video forced black
  // ST_IDLE | CPU load/readback active, video reads RAM
  localparam logic [0:0] ST_INIT = 1'b0;
  localparam logic [0:0] ST_IDLE = 1'b1;

  localparam logic [1:0] CMP_R = 2'd0;
  localparam logic [1:0] CMP_G = 2'd1;
  localparam logic [1:0] CMP_B = 2'd2;

  logic [0:0]  r_state;
  logic [8:0]  r_init_cnt;
  logic [1:0]  r_comp;
  logic [7:0]  r_index;
  logic [7:0]  r_shadow_r;
  logic [7:0]  r_shadow_g;
  logic [23:0] r_mem [256];

  logic        w_idle;
  logic [7:0]  w_n;
  logic [23:0] w_init_data;
  logic        w_cpu_wr;
  logic        w_wr_en;
  logic [7:0]  w_wr_addr;
  logic [23:0] w_wr_data;
  logic        w_rd_req;
  logic        w_step;

  assign w_idle    = (r_state == ST_IDLE);
  assign w_n       = r_init_cnt[7:0];
  assign init_busy = ~r_init_cnt[8];

  always_comb begin
    w_init_data = 24'd0;
    if (INIT_PALETTE == 0)
      w_init_data = {w_n[7:5], w_n[7:5], w_n[7:6],
                     w_n[4:2], w_n[4:2], w_n[4:3],
                     {4{w_n[1:0]}}};
  end

  // Only the B byte commits a triple; the index strobe pre-empts a same-cycle data byte.
  assign w_cpu_wr  = w_idle & cpu_data_strobe & ~cpu_index_strobe & (r_comp == CMP_B);
  assign w_wr_en   = ~w_idle | w_cpu_wr;
  assign w_wr_addr = w_idle ? r_index : w_n;
  assign w_wr_data = w_idle ? {r_shadow_r, r_shadow_g, cpu_data} : w_init_data;

`ifdef SUPER_PALETTE_READBACK_EN
  assign w_rd_req = cpu_rd_strobe;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cpu_rd_data <= 8'd0;
    end else if (w_idle && cpu_rd_strobe && !cpu_index_strobe && !cpu_data_strobe) begin
      case (r_comp)
        CMP_R:   cpu_rd_data <= r_mem[r_index][23:16];
        CMP_G:   cpu_rd_data <= r_mem[r_index][15:8];
        default: cpu_rd_data <= r_mem[r_index][7:0];
      endcase
    end
  end
`else
  logic w_unused_rd;
  assign w_unused_rd = cpu_rd_strobe;
  assign w_rd_req    = 1'b0;
  assign cpu_rd_data = 8'd0;
`endif

  assign w_step = cpu_data_strobe | w_rd_req;

  always_ff @(posedge clk) begin
    if (w_wr_en)
      r_mem[w_wr_addr] <= w_wr_data;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= ST_INIT;
      r_init_cnt <= 9'd0;
      r_comp     <= CMP_R;
      r_index    <= INIT_START_INDEX;
      r_shadow_r <= 8'd0;
      r_shadow_g <= 8'd0;
    end else if (!w_idle) begin
      r_init_cnt <= r_init_cnt + 9'd1;
      if (w_n == 8'hFF)
        r_state <= ST_IDLE;
    end else if (cpu_index_strobe) begin
      r_index <= cpu_data;
      r_comp  <= CMP_R;
    end else if (w_step) begin
      if (cpu_data_strobe && r_comp == CMP_R) r_shadow_r <= cpu_data;
      if (cpu_data_strobe && r_comp == CMP_G) r_shadow_g <= cpu_data;
      if (r_comp == CMP_R) begin
        r_comp <= CMP_G;
      end else if (r_comp == CMP_G) begin
        r_comp <= CMP_B;
      end else begin
        r_comp  <= CMP_R;
        r_index <= r_index + 8'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      palette_r <= 8'd0;
      palette_g <= 8'd0;
      palette_b <= 8'd0;
    end else if (!w_idle) begin
      palette_r <= 8'd0;
      palette_g <= 8'd0;
      palette_b <= 8'd0;
    end else begin
      {palette_r, palette_g, palette_b} <= r_mem[palette_addr];
    end
  end

endmodule

// File: tb/tb_vdp_super_palette.sv
// Bench for vdp_super_palette: vector table, hand sequences and random traffic
// compared against a colour-table reference model.
module tb_vdp_super_palette;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [7:0] palette_addr = 8'd0;
  logic [7:0] cpu_data = 8'd0;
  logic       cpu_index_strobe = 1'b0;
  logic       cpu_data_strobe = 1'b0;
  logic       cpu_rd_strobe = 1'b0;
  logic [7:0] palette_r, palette_g, palette_b, cpu_rd_data;
  logic       init_busy;

  always #5 clk = ~clk;

  vdp_super_palette #(.INIT_PALETTE(0), .INIT_START_INDEX(8'd0)) dut (
    .clk(clk), .reset_n(reset_n), .palette_addr(palette_addr),
    .palette_r(palette_r), .palette_g(palette_g), .palette_b(palette_b),
    .cpu_index_strobe(cpu_index_strobe), .cpu_data_strobe(cpu_data_strobe),
    .cpu_data(cpu_data), .cpu_rd_strobe(cpu_rd_strobe),
    .cpu_rd_data(cpu_rd_data), .init_busy(init_busy)
  );

`ifdef SUPER_PALETTE_READBACK_EN
  localparam bit RB = 1'b1;
`else
  localparam bit RB = 1'b0;
`endif

  int errors = 0;
  int checks = 0;

  logic [23:0] mem_m [256];
  int          init_left;
  int          pos;
  logic [7:0]  idx_m, sr, sg, exp_rd;
  logic [23:0] exp_pal;

  typedef struct {
    bit         is;
    bit         ds;
    logic [7:0] d;
    logic [7:0] a;
    bit         chk;
    logic [23:0] exp;
  } vec_t;
  vec_t tbl[$];

  // Default palette as evenly spaced intensity levels per channel.
  function automatic logic [23:0] default_colour(int n);
    int r3, g3, b2;
    r3 = (n >> 5) & 7;
    g3 = (n >> 2) & 7;
    b2 = n & 3;
    return {8'((r3 * 255 + 3) / 7), 8'((g3 * 255 + 3) / 7), 8'(b2 * 85)};
  endfunction

  function automatic vec_t v(bit is, bit ds, logic [7:0] d, logic [7:0] a, bit c, logic [23:0] e);
    vec_t t;
    t.is = is; t.ds = ds; t.d = d; t.a = a; t.chk = c; t.exp = e;
    return t;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    init_left = 256;
    pos = 0;
    idx_m = 8'd0;
    sr = 8'd0;
    sg = 8'd0;
    exp_rd = 8'd0;
    exp_pal = 24'd0;
    for (int n = 0; n < 256; n++) mem_m[n] = default_colour(n);
  endtask

  // Called just after a falling edge: drive, predict the next rising edge, compare at the next falling edge.
  task automatic cyc(bit is, bit ds, bit rs, logic [7:0] d, logic [7:0] a);
    cpu_index_strobe = is;
    cpu_data_strobe  = ds;
    cpu_rd_strobe    = rs;
    cpu_data         = d;
    palette_addr     = a;
    if (init_left > 0) begin
      exp_pal = 24'd0;
      init_left--;
    end else begin
      exp_pal = mem_m[a];
      if (is) begin
        idx_m = d;
        pos = 0;
      end else if (ds) begin
        if (pos == 0) sr = d;
        else if (pos == 1) sg = d;
        else begin
          mem_m[idx_m] = {sr, sg, d};
          idx_m = idx_m + 8'd1;
        end
        pos = (pos + 1) % 3;
      end else if (rs && RB) begin
        exp_rd = 8'(mem_m[idx_m] >> (8 * (2 - pos)));
        if (pos == 2) idx_m = idx_m + 8'd1;
        pos = (pos + 1) % 3;
      end
    end
    @(negedge clk);
    chk("video", {palette_r, palette_g, palette_b}, exp_pal);
    chk("busy", init_busy, (init_left > 0));
    chk("rd_data", cpu_rd_data, exp_rd);
  endtask

  task automatic do_reset();
    cpu_index_strobe = 1'b0;
    cpu_data_strobe  = 1'b0;
    cpu_rd_strobe    = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    model_reset();
    chk("rst_video", {palette_r, palette_g, palette_b}, 24'd0);
    chk("rst_busy", init_busy, 1'b1);
    chk("rst_rd", cpu_rd_data, 8'd0);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic run_init();
    int n;
    n = 0;
    while (init_busy === 1'b1 && n < 300) begin
      cyc(1'($urandom), 1'($urandom), 1'($urandom), 8'($urandom), 8'($urandom));
      n++;
    end
    chk("init_cycles", n, 256);
  endtask

  initial begin
    @(negedge clk);
    do_reset();
    run_init();

    tbl.push_back(v(0, 0, 8'h00, 8'hE3, 1, 24'hFF00FF));
    tbl.push_back(v(0, 0, 8'h00, 8'h00, 1, 24'h000000));
    tbl.push_back(v(1, 0, 8'h05, 8'h00, 0, 24'h0));
    tbl.push_back(v(0, 1, 8'h12, 8'h00, 0, 24'h0));
    tbl.push_back(v(0, 1, 8'h34, 8'h00, 0, 24'h0));
    tbl.push_back(v(0, 1, 8'h56, 8'h05, 1, 24'h002455));
    tbl.push_back(v(0, 1, 8'hAA, 8'h05, 1, 24'h123456));
    tbl.push_back(v(0, 1, 8'hBB, 8'h00, 0, 24'h0));
    tbl.push_back(v(0, 1, 8'hCC, 8'h06, 1, 24'h0024AA));
    tbl.push_back(v(0, 0, 8'h00, 8'h06, 1, 24'hAABBCC));
    tbl.push_back(v(1, 0, 8'hFF, 8'h00, 0, 24'h0));
    tbl.push_back(v(0, 1, 8'h01, 8'h00, 0, 24'h0));
    tbl.push_back(v(0, 1, 8'h02, 8'h00, 0, 24'h0));
    tbl.push_back(v(0, 1, 8'h03, 8'h00, 0, 24'h0));
    tbl.push_back(v(0, 1, 8'h04, 8'h00, 0, 24'h0));
    tbl.push_back(v(0, 1, 8'h05, 8'h00, 0, 24'h0));
    tbl.push_back(v(0, 1, 8'h06, 8'hFF, 1, 24'h010203));
    tbl.push_back(v(0, 0, 8'h00, 8'h00, 1, 24'h040506));
    tbl.push_back(v(1, 0, 8'h10, 8'h00, 0, 24'h0));
    tbl.push_back(v(0, 1, 8'h11, 8'h00, 0, 24'h0));
    tbl.push_back(v(0, 1, 8'h22, 8'h00, 0, 24'h0));
    tbl.push_back(v(1, 0, 8'h20, 8'h00, 0, 24'h0));
    tbl.push_back(v(0, 1, 8'h33, 8'h00, 0, 24'h0));
    tbl.push_back(v(0, 1, 8'h44, 8'h00, 0, 24'h0));
    tbl.push_back(v(0, 1, 8'h55, 8'h00, 0, 24'h0));
    tbl.push_back(v(0, 0, 8'h00, 8'h10, 1, 24'h009200));
    tbl.push_back(v(0, 0, 8'h00, 8'h20, 1, 24'h334455));
    tbl.push_back(v(1, 1, 8'h30, 8'h00, 0, 24'h0));
    tbl.push_back(v(0, 1, 8'h01, 8'h00, 0, 24'h0));
    tbl.push_back(v(0, 1, 8'h02, 8'h00, 0, 24'h0));
    tbl.push_back(v(0, 1, 8'h03, 8'h00, 0, 24'h0));
    tbl.push_back(v(0, 0, 8'h00, 8'h30, 1, 24'h010203));

    foreach (tbl[i]) begin
      cyc(tbl[i].is, tbl[i].ds, 1'b0, tbl[i].d, tbl[i].a);
      if (tbl[i].chk) chk($sformatf("tbl%0d", i), {palette_r, palette_g, palette_b}, tbl[i].exp);
    end

    // Video parked on the entry the CPU is completing.
    cyc(1, 0, 0, 8'h07, 8'h07);
    cyc(0, 1, 0, 8'h77, 8'h07);
    cyc(0, 1, 0, 8'h88, 8'h07);
    cyc(0, 1, 0, 8'h99, 8'h07);
    chk("coll_old", {palette_r, palette_g, palette_b}, 24'h0024FF);
    cyc(0, 0, 0, 8'h00, 8'h07);
    chk("coll_new", {palette_r, palette_g, palette_b}, 24'h778899);

    // Readback of entry 5, then a write that follows the shared index.
    cyc(1, 0, 0, 8'h05, 8'h00);
    cyc(0, 0, 1, 8'h00, 8'h00);
    chk("rb_r", cpu_rd_data, RB ? 8'h12 : 8'h00);
    cyc(0, 0, 1, 8'h00, 8'h00);
    chk("rb_g", cpu_rd_data, RB ? 8'h34 : 8'h00);
    cyc(0, 0, 1, 8'h00, 8'h05);
    chk("rb_b", cpu_rd_data, RB ? 8'h56 : 8'h00);
    cyc(0, 0, 0, 8'h00, 8'h05);
    chk("rb_entry5", {palette_r, palette_g, palette_b}, 24'h123456);
    cyc(0, 1, 0, 8'hDE, 8'h00);
    cyc(0, 1, 0, 8'hAD, 8'h00);
    cyc(0, 1, 0, 8'hBF, 8'h00);
    cyc(0, 0, 0, 8'h00, RB ? 8'h06 : 8'h05);
    chk("rb_next", {palette_r, palette_g, palette_b}, 24'hDEADBF);

    for (int k = 0; k < 3000; k++) begin
      bit is, ds, rs;
      logic [7:0] a;
      is = ($urandom_range(0, 7) == 0);
      ds = ($urandom_range(0, 1) == 1);
      rs = ($urandom_range(0, 3) == 0);
      a  = ($urandom_range(0, 3) == 0) ? idx_m : 8'($urandom);
      cyc(is, ds, rs, 8'($urandom), a);
    end

    // Reset in the middle of a triple: sequencer restarts, partial data is lost.
    cyc(1, 0, 0, 8'h09, 8'h00);
    cyc(0, 1, 0, 8'hE1, 8'h00);
    cyc(0, 1, 0, 8'hE2, 8'h00);
    do_reset();
    run_init();
    cyc(0, 1, 0, 8'hD1, 8'h00);
    cyc(0, 1, 0, 8'hD2, 8'h00);
    cyc(0, 1, 0, 8'hD3, 8'h00);
    cyc(0, 0, 0, 8'h00, 8'h00);
    chk("post_rst_entry0", {palette_r, palette_g, palette_b}, 24'hD1D2D3);
    cyc(0, 0, 0, 8'h00, 8'h09);
    chk("post_rst_entry9", {palette_r, palette_g, palette_b}, default_colour(9));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/vdp_super_palette.md
Name: vdp_super_palette

Overview:
- 256-entry 24-bit RGB palette for the super-res/super-mid video path. Sits directly downstream of the super-res renderer.
- Video read port: takes the renderer's 8-bit palette index and returns registered R/G/B to the video output mux.
- CPU port: loads entries as an index latch followed by R, G, B byte triples, with auto-increment.
- After reset, a self-initialising sequencer fills the RAM with a default palette.

Parameters:
- INIT_PALETTE, 0, default contents. 0 = RGB 3-3-2 expansion; 1 = all entries black.
- INIT_START_INDEX, 0, first CPU index selected after the init sequence completes.

Ports:
- clk  in  1  video/system clock.
- reset_n  in  1  asynchronous, active-low reset.
- palette_addr  in  8  video lookup index from super-res renderer.
- palette_r  out  8  red of entry addressed on the previous cycle.
- palette_g  out  8  green of entry addressed on the previous cycle.
- palette_b  out  8  blue of entry addressed on the previous cycle.
- cpu_index_strobe  in  1  one-cycle pulse; latch cpu_data as the entry index.
- cpu_data_strobe  in  1  one-cycle pulse; cpu_data is the next colour component.
- cpu_data  in  8  CPU data byte.
- cpu_rd_strobe  in  1  one-cycle pulse; read the next component (feature-gated).
- cpu_rd_data  out  8  readback byte (feature-gated).
- init_busy  out  1  high while the default palette is being written.

Behaviour:
- Reset (reset_n low, asynchronous) clears:
  - palette_r/g/b = 0, cpu_rd_data = 0, init_busy = 1;
  - state = INIT, init counter = 0, component = R, index = INIT_START_INDEX;
  - shadow r/g = 0.
- RAM has no reset. Contents are undefined until INIT completes.
- INIT state:
  - Each cycle, write entry n (n = 0..255), then n++.
  - INIT_PALETTE=0: R = {n[7:5],n[7:5],n[7:6]}, G = {n[4:2],n[4:2],n[4:3]}, B = {n[1:0],n[1:0],n[1:0],n[1:0]}. INIT_PALETTE=1: all zero.
  - After writing n = 255, go to IDLE. init_busy falls on the following edge, so it is high for exactly 256 cycles after reset release.
  - During INIT: all CPU strobes are ignored and palette_r/g/b are forced to 0.
- IDLE state, CPU write path:
  - cpu_index_strobe: index <= cpu_data; component <= R.
  - cpu_data_strobe when component = R: shadow_r <= cpu_data; component <= G.
  - cpu_data_strobe when component = G: shadow_g <= cpu_data; component <= B.
  - cpu_data_strobe when component = B: RAM[index] <= {shadow_r, shadow_g, cpu_data} on that edge; index <= index+1 (wraps 255 -> 0); component <= R.
  - Index and data strobe in the same cycle: the index strobe wins and the data byte is dropped.
  - A partial triple followed by an index strobe is discarded; RAM is unchanged.
- Video read path (dual-port RAM, video on a dedicated read port):
  - palette_r/g/b <= RAM[palette_addr] every cycle. Latency is 1 clock.
  - CPU write to the same address in the same cycle: video sees the old value that cycle and the new value on the following lookup (read-before-write).
  - No stall or handshake on the video side. The video port never blocks the CPU.
- Arithmetic: index is 8-bit modulo 256. Init counter is 9-bit; its MSB marks done.

Optional Feature:
- Macro: SUPER_PALETTE_READBACK_EN.
- Defined, cpu_rd_strobe in IDLE:
  - cpu_rd_data <= component byte of RAM[index] (R, G or B per current component), valid on the edge after the strobe.
  - Component advances exactly as for a write; index increments after B, with no RAM write.
  - Read and write strobes share the same component and index state.
  - Read and data strobe in the same cycle: the data strobe wins and the read is dropped.
- Not defined: cpu_rd_strobe is ignored, cpu_rd_data is constant 0, and no CPU-side RAM read port is built.

Test Plan:
- Release reset with INIT_PALETTE=0 -> init_busy high for exactly 256 cycles; then palette_addr=8'hE3 gives R=FF, G=00, B=FF one cycle later; palette_addr=8'h00 gives 000000.
- Index 5, data 12,34,56 -> palette_addr=5 gives R=12, G=34, B=56; a following triple AA,BB,CC lands in entry 6.
- Index FF, write two triples -> second triple lands in entry 0 (wrap-around).
- Index 10, data 11,22, then index 20, data 33,44,55 -> entry 10 keeps its init value; entry 20 = 334455.
- Video holds palette_addr=7 while the CPU completes a triple to entry 7 -> old colour on the write cycle, new colour from the next cycle; reset_n pulsed mid-triple -> INIT restarts and the partial triple is lost.
- With SUPER_PALETTE_READBACK_EN: index 5 then three reads -> 12, 34, 56, then index is 6. Without the macro: reads return 0 and entry 5 is unchanged.
